// File: rtl/cv32e40x_fetch_push_ctrl.sv
// rtl/cv32e40x_fetch_push_ctrl.sv - instruction fetch request issue and FIFO push control
//
// Purpose: producer end of the instruction read-data FIFO. Issues word fetches on an
// OBI-style bus and pushes every live response (rdata, addr, err) into the FIFO. Credit
// logic keeps the FIFO from overflowing; branches flush the FIFO and discard responses
// that are still in flight.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   fetch_enable_i          allow new requests
//   branch_i, branch_addr_i redirect pulse and target ([1:0] ignored)
//   fifo_cnt_i              registered FIFO occupancy
//   fifo_push_o/rdata/addr/err, fifo_flush_o   FIFO write side
//   bus_req_o/addr_o, bus_gnt_i, bus_rvalid_i/rdata_i/err_i   OBI-style bus
//   busy_o                  outstanding transactions or request active
//   discard_cnt_o           dropped-response counter
//
// Optional feature: define FETCH_DISCARD_CNT_EN to enable the saturating discard counter;
// otherwise discard_cnt_o is tied to zero.

module cv32e40x_fetch_push_ctrl #(
    parameter int DEPTH           = 8,
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             fetch_enable_i,
    input  logic             branch_i,
    input  logic [31:0]      branch_addr_i,
    input  logic [CNT_W-1:0] fifo_cnt_i,
    output logic             fifo_push_o,
    output logic [31:0]      fifo_rdata_o,
    output logic [31:0]      fifo_addr_o,
    output logic             fifo_err_o,
    output logic             fifo_flush_o,
    output logic             bus_req_o,
    output logic [31:0]      bus_addr_o,
    input  logic             bus_gnt_i,
    input  logic             bus_rvalid_i,
    input  logic [31:0]      bus_rdata_i,
    input  logic             bus_err_i,
    output logic             busy_o,
    output logic [15:0]      discard_cnt_o
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    // Wide enough that fifo_cnt + live + 1 and live + drop never wrap.
    localparam int SW = ((CNT_W > OW) ? CNT_W : OW) + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_addr_q, fetch_addr_d;
    logic [31:0]   resp_addr_q, resp_addr_d;
    logic [31:0]   hold_addr_q, hold_addr_d;
    logic          hold_q, hold_d;
    logic          err_seen_q, err_seen_d;
    logic [OW-1:0] live_q, live_d;
    logic [OW-1:0] drop_q, drop_d;

    logic [SW-1:0] cnt_x, live_x, drop_x, live_nx, drop_nx;
    logic [31:0]   target;
    logic          credit, credit_post, req_int, gnt_acc;
    logic          rv_drop, rv_push, gnt_live, gnt_hold;
    logic          unused_addr_bits;

    assign target           = {branch_addr_i[31:2], 2'b00};
    assign unused_addr_bits = ^branch_addr_i[1:0];

    assign cnt_x  = SW'(fifo_cnt_i);
    assign live_x = SW'(live_q);
    assign drop_x = SW'(drop_q);

    // A response is dropped while older (pre-branch) responses are still owed, and
    // always in the branch cycle itself.
    assign rv_drop = bus_rvalid_i & (branch_i | (drop_q != '0));
    assign rv_push = bus_rvalid_i & ~rv_drop;

    assign err_seen_d = branch_i ? 1'b0 : (err_seen_q | (rv_push & bus_err_i));

    assign credit = fetch_enable_i & ~branch_i & ~err_seen_d
                  & ((cnt_x + live_x) < SW'(DEPTH))
                  & ((live_x + drop_x) < SW'(MAX_OUTSTANDING));

    assign req_int  = ((state_q == REQ) | ((state_q == IDLE) & credit)) & ~rst_i;
    assign gnt_acc  = req_int & bus_gnt_i;
    // A grant for a request that was already pending when a branch hit belongs to the
    // old stream and must be discarded.
    assign gnt_hold = gnt_acc & hold_q;
    assign gnt_live = gnt_acc & ~hold_q;

    always_comb begin
        live_nx = live_x;
        drop_nx = drop_x;
        if (branch_i) begin
            live_nx = '0;
            drop_nx = drop_x + live_x + SW'(gnt_acc) - SW'(bus_rvalid_i);
        end else begin
            live_nx = live_x + SW'(gnt_live) - SW'(rv_push);
            drop_nx = drop_x + SW'(gnt_hold) - SW'(rv_drop);
        end
    end

    // Credit for keeping the request up in the cycle after a grant. The FIFO side counts
    // the just-granted request; a same-cycle push stays in live_q until the FIFO count
    // absorbs it, so this never overestimates free space.
    assign credit_post = fetch_enable_i & ~branch_i & ~err_seen_d
                       & ((cnt_x + live_x + SW'(1)) < SW'(DEPTH))
                       & ((live_nx + drop_nx) < SW'(MAX_OUTSTANDING));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (credit && !gnt_acc)  state_d = REQ;
                else if (credit_post && gnt_acc) state_d = REQ;
                else if (err_seen_d)     state_d = ERR;
                else                     state_d = IDLE;
            end
            REQ: begin
                if (gnt_acc) begin
                    if (credit_post)     state_d = REQ;
                    else if (err_seen_d) state_d = ERR;
                    else                 state_d = IDLE;
                end
            end
            ERR: begin
                if (branch_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fetch_addr_d = fetch_addr_q;
        resp_addr_d  = resp_addr_q;
        hold_d       = hold_q;
        hold_addr_d  = hold_addr_q;
        live_d       = OW'(live_nx);
        drop_d       = OW'(drop_nx);

        if (branch_i) begin
            fetch_addr_d = target;
            resp_addr_d  = target;
        end else begin
            if (gnt_live) fetch_addr_d = fetch_addr_q + 32'd4;
            if (rv_push)  resp_addr_d  = resp_addr_q + 32'd4;
        end

        // A request cannot be withdrawn once raised: keep presenting the old address.
        if (branch_i && (state_q == REQ) && !gnt_acc) begin
            hold_d      = 1'b1;
            hold_addr_d = hold_q ? hold_addr_q : fetch_addr_q;
        end else if (gnt_acc) begin
            hold_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            fetch_addr_q <= '0;
            resp_addr_q  <= '0;
            hold_addr_q  <= '0;
            hold_q       <= 1'b0;
            err_seen_q   <= 1'b0;
            live_q       <= '0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            resp_addr_q  <= resp_addr_d;
            hold_addr_q  <= hold_addr_d;
            hold_q       <= hold_d;
            err_seen_q   <= err_seen_d;
            live_q       <= live_d;
            drop_q       <= drop_d;
        end
    end

`ifdef FETCH_DISCARD_CNT_EN
    logic [15:0] discard_q, discard_d;

    always_comb begin
        discard_d = discard_q;
        if (rv_drop && (discard_q != 16'hFFFF)) discard_d = discard_q + 16'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) discard_q <= '0;
        else       discard_q <= discard_d;
    end

    assign discard_cnt_o = discard_q;
`else
    assign discard_cnt_o = 16'h0000;
`endif

    assign bus_req_o    = req_int;
    assign bus_addr_o   = hold_q ? hold_addr_q : fetch_addr_q;
    assign fifo_push_o  = rv_push & ~rst_i;
    assign fifo_rdata_o = fifo_push_o ? bus_rdata_i : 32'h0;
    assign fifo_err_o   = fifo_push_o & bus_err_i;
    assign fifo_addr_o  = fifo_push_o ? resp_addr_q : 32'h0;
    assign fifo_flush_o = branch_i & ~rst_i;
    assign busy_o       = (live_q != '0) | (drop_q != '0) | req_int;

endmodule
